// File: rtl/bus_bridge_n.sv
// Peripheral bridge from the CPU M-stage data port to NUM_CH memory-mapped devices.
// Decodes per-channel base/mask windows, waits for device ready with a timeout, and reports errors.
module bus_bridge_n #(
  parameter int                   NUM_CH    = 2,
  parameter logic [NUM_CH*32-1:0] BASE      = {32'h0000_7F10, 32'h0000_7F00},
  parameter logic [NUM_CH*32-1:0] MASK      = {32'h0000_000F, 32'h0000_000F},
  parameter logic [NUM_CH-1:0]    WORD_ONLY = 2'b11,
  parameter int                   TIMEOUT   = 15
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   cpu_req_i,
  input  logic                   cpu_we_i,
  input  logic [31:0]            cpu_addr_i,
  input  logic [31:0]            cpu_wdata_i,
  input  logic [3:0]             cpu_byteen_i,
  output logic                   cpu_stall_o,
  output logic                   cpu_done_o,
  output logic                   cpu_err_o,
  output logic                   cpu_rvalid_o,
  output logic [31:0]            cpu_rdata_o,
  output logic [NUM_CH-1:0]      dev_sel_o,
  output logic [31:0]            dev_addr_o,
  output logic                   dev_we_o,
  output logic [31:0]            dev_wdata_o,
  output logic [3:0]             dev_byteen_o,
  input  logic [NUM_CH*32-1:0]   dev_rdata_i,
  input  logic [NUM_CH-1:0]      dev_ready_i
);

  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [3:0]      be_q, be_d;
  logic            we_q, we_d;

  logic [31:0]     base_a [NUM_CH];
  logic [31:0]     mask_a [NUM_CH];
  logic [31:0]     rd_a   [NUM_CH];
  logic [NUM_CH-1:0] hit;
  logic [SW-1:0]   hit_idx;
  logic            any_hit;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_win
    assign base_a[gi] = BASE[32*gi +: 32];
    assign mask_a[gi] = MASK[32*gi +: 32];
    assign rd_a[gi]   = dev_rdata_i[32*gi +: 32];
    assign hit[gi]    = ((cpu_addr_i & ~mask_a[gi]) == (base_a[gi] & ~mask_a[gi]));
  end

  // Scan downwards so the lowest matching window takes priority.
  always_comb begin
    hit_idx = '0;
    any_hit = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_idx = SW'(i);
        any_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          we_d    = cpu_we_i;
          wdata_d = cpu_wdata_i;
          be_d    = cpu_byteen_i;
          sel_d   = hit_idx;
          addr_d  = cpu_addr_i & mask_a[hit_idx];
          cnt_d   = '0;
          if (!any_hit) begin
            state_d = ERR;
          end else if (cpu_we_i && WORD_ONLY[hit_idx] && (cpu_byteen_i != 4'b1111)) begin
            state_d = ERR;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (dev_ready_i[sel_q]) begin
          state_d = RESP;
          if (!we_q) rdata_d = rd_a[sel_q];
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  assign cpu_stall_o  = (state_q != IDLE);
  assign cpu_done_o   = (state_q == RESP) || (state_q == ERR);
  assign cpu_err_o    = (state_q == ERR);
  assign cpu_rvalid_o = (state_q == RESP) && !we_q;
  assign cpu_rdata_o  = rdata_q;
  assign dev_sel_o    = (state_q == ACCESS) ? (NUM_CH'(1) << sel_q) : '0;
  assign dev_we_o     = (state_q == ACCESS) && we_q;
  assign dev_addr_o   = addr_q;
  assign dev_wdata_o  = wdata_q;
  assign dev_byteen_o = be_q;

endmodule

// File: tb/tb_bus_bridge_n.sv
// Directed bench for bus_bridge_n: the stimulus task queues expected responses,
// a monitor compares them whenever the bridge pulses cpu_done.
module tb_bus_bridge_n;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_byteen = '0;
  logic        cpu_stall, cpu_done, cpu_err, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic [1:0]  dev_sel;
  logic [31:0] dev_addr, dev_wdata;
  logic        dev_we;
  logic [3:0]  dev_byteen;
  logic [63:0] dev_rdata = '0;
  logic [1:0]  dev_ready = '0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        err;
    logic        rvalid;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];
  logic [31:0] last_rd = '0;

  bus_bridge_n dut (
    .clk_i(clk), .reset_i(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_byteen_i(cpu_byteen),
    .cpu_stall_o(cpu_stall), .cpu_done_o(cpu_done), .cpu_err_o(cpu_err),
    .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .dev_sel_o(dev_sel), .dev_addr_o(dev_addr), .dev_we_o(dev_we),
    .dev_wdata_o(dev_wdata), .dev_byteen_o(dev_byteen),
    .dev_rdata_i(dev_rdata), .dev_ready_i(dev_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every cpu_done must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cpu_rvalid && !cpu_done) chk("rvalid_without_done", 32'(cpu_rvalid), 32'd0);
      if (cpu_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(cpu_done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_err", 32'(cpu_err), 32'(e.err));
          chk("resp_rvalid", 32'(cpu_rvalid), 32'(e.rvalid));
          chk("resp_rdata", cpu_rdata, e.rdata);
        end
      end
    end
  end

  // One CPU access. wait_n = ready on ACCESS cycle wait_n+1 (large = never);
  // noise is driven on dev_ready while the selected channel is not ready.
  task automatic xact(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int wait_n,
                      input logic [1:0] noise, input logic [1:0] exp_sel,
                      input logic [31:0] exp_daddr, input int exp_sel_cyc, input logic exp_err);
    int sel_cyc = 0, we_cyc = 0, stall_cyc = 0, n = 0;
    logic bad_bus = 1'b0;
    exp_t e;
    e.err    = exp_err;
    e.rvalid = !we && !exp_err;
    if (e.rvalid) last_rd = exp_sel[1] ? dev_rdata[63:32] : dev_rdata[31:0];
    e.rdata  = last_rd;
    exp_q.push_back(e);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_byteen = be;
    @(posedge clk);
    #1 cpu_req = 1'b0; cpu_addr = 32'hFFFF_FFFF; cpu_wdata = '0; cpu_byteen = '0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (!cpu_stall) break;
      stall_cyc++;
      if (dev_we) we_cyc++;
      if (dev_sel != 0) begin
        sel_cyc++;
        if (dev_sel !== exp_sel || dev_addr !== exp_daddr || dev_we !== we ||
            (we && (dev_wdata !== wdata || dev_byteen !== be))) bad_bus = 1'b1;
      end
      dev_ready = (dev_sel != 0 && sel_cyc == wait_n + 1) ? dev_sel : noise & ~dev_sel;
    end
    dev_ready = '0;
    if (n >= 40) chk({name, "_stall_bound"}, 32'(n), 32'd0);
    chk({name, "_sel_cycles"}, 32'(sel_cyc), 32'(exp_sel_cyc));
    chk({name, "_we_cycles"}, 32'(we_cyc), (we && !exp_err) || (we && exp_sel_cyc > 0) ? 32'(exp_sel_cyc) : 32'd0);
    chk({name, "_stall_cycles"}, 32'(stall_cyc), 32'(exp_sel_cyc + 1));
    chk({name, "_dev_bus_stable"}, 32'(bad_bus), 32'd0);
  endtask

  task automatic chk_idle_zero(input string name);
    chk({name, "_ctl"}, {26'd0, cpu_stall, cpu_done, cpu_err, cpu_rvalid, dev_sel, dev_we}, 32'd0);
    chk({name, "_rdata"}, cpu_rdata, 32'd0);
    chk({name, "_dev_addr"}, dev_addr, 32'd0);
  endtask

  initial begin
    #1 chk_idle_zero("reset_state");
    #20;
    @(negedge clk) reset = 1'b0;
    dev_rdata = {32'hAAAA_5555, 32'h1234_5678};

    // name, we, addr, wdata, be, wait, noise, exp_sel, exp_daddr, sel_cyc, err
    xact("rd_ch0_0ws",   1'b0, 32'h0000_7F04, 32'h0,         4'hF, 0,  2'b00, 2'b01, 32'h4, 1,  1'b0);
    xact("wr_ch1_3ws",   1'b1, 32'h0000_7F18, 32'hDEAD_BEEF, 4'hF, 3,  2'b00, 2'b10, 32'h8, 4,  1'b0);
    xact("unmapped",     1'b0, 32'h0000_7F20, 32'h0,         4'hF, 0,  2'b00, 2'b00, 32'h0, 0,  1'b1);
    xact("partial_wr",   1'b1, 32'h0000_7F00, 32'h5555_AAAA, 4'h3, 0,  2'b00, 2'b00, 32'h0, 0,  1'b1);
    xact("timeout_ch1",  1'b0, 32'h0000_7F1C, 32'h0,         4'hF, 99, 2'b01, 2'b10, 32'hC, 15, 1'b1);
    dev_rdata = {32'hCAFE_F00D, 32'h0101_0101};
    xact("rd_ch1_1ws",   1'b0, 32'h0000_7F10, 32'h0,         4'hF, 1,  2'b01, 2'b10, 32'h0, 2,  1'b0);
    xact("wr_ch0_0ws",   1'b1, 32'h0000_7F0C, 32'h0BAD_CAFE, 4'hF, 0,  2'b00, 2'b01, 32'hC, 1,  1'b0);
    xact("unmapped_hi",  1'b0, 32'h0001_7F04, 32'h0,         4'hF, 0,  2'b00, 2'b00, 32'h0, 0,  1'b1);

    // Mid-access reset: request ch0 read, never ready, reset in ACCESS cycle 2.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_7F08;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_sel", 32'(dev_sel), 32'h1);
    #2 reset = 1'b1;
    #1 chk_idle_zero("async_reset");
    last_rd = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    dev_rdata = {32'h2222_2222, 32'h0BAD_F00D};
    xact("rd_after_rst", 1'b0, 32'h0000_7F04, 32'h0,         4'hF, 0,  2'b00, 2'b01, 32'h4, 1,  1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
